// File: rtl/clk_div_pkg.sv
// Shared encodings and helpers for the clk_div_n programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    CLK_DIV_MODE_PULSE = 1'b0,
    CLK_DIV_MODE_HALF  = 1'b1
  } clk_div_mode_e;

  localparam int unsigned CLK_DIV_MIN = 2;

  // Divisors 0 and 1 cannot produce a period boundary distinct from the next, so lift them to 2.
  function automatic logic [31:0] clk_div_clamp(input logic [31:0] div);
    return (div < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/clk_div_negstage.sv
// Falling-edge retiming stage: stretches an odd-divisor half-mode high phase by half a clock.
module clk_div_negstage (
  input  logic clock,
  input  logic reset,
  input  logic pos_term,
  input  logic odd_half,
  output logic div_out
);

  logic neg_q;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_term & odd_half;
    end
  end

  assign div_out = pos_term | neg_q;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with period-boundary divisor/mode updates.
// Optional CLK_DIV_HALF_CYCLE_EN adds a negedge stage for exact N/2 duty on odd N.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_RESET = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  input  logic             div_load,
  output logic             div_out,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_q, div_nxt;
  logic [WIDTH-1:0] pend_div, pdiv_nxt;
  clk_div_mode_e    mode_q, mode_nxt, pend_mode, pmode_nxt;
  logic             pend_nxt;
  logic             run_q;
  logic             boundary;
  logic [WIDTH-1:0] div_in_c;
  clk_div_mode_e    mode_in_e;
  logic [WIDTH-1:0] half_lo, half_hi, thr;
  logic             tick_nxt, term_nxt, term_q;

  assign div_in_c  = WIDTH'(clk_div_clamp(32'(div_in)));
  assign mode_in_e = clk_div_mode_e'(mode_in);

  // run_q low on an enabled edge marks k = 0, which is treated as a period boundary.
  always_comb begin
    cnt_nxt   = '0;
    div_nxt   = div_q;
    mode_nxt  = mode_q;
    pdiv_nxt  = pend_div;
    pmode_nxt = pend_mode;
    pend_nxt  = pending;
    boundary  = 1'b0;
    if (!enable) begin
      if (div_load) begin
        div_nxt  = div_in_c;
        mode_nxt = mode_in_e;
        pend_nxt = 1'b0;
      end
    end else begin
      boundary = !run_q || (cnt == div_q - WIDTH'(1));
      if (boundary) begin
        if (div_load) begin
          div_nxt  = div_in_c;
          mode_nxt = mode_in_e;
        end else if (pending) begin
          div_nxt  = pend_div;
          mode_nxt = pend_mode;
        end
        pend_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
        if (div_load) begin
          pdiv_nxt  = div_in_c;
          pmode_nxt = mode_in_e;
          pend_nxt  = 1'b1;
        end
      end
    end
  end

  assign half_lo = div_nxt >> 1;
  assign half_hi = half_lo + WIDTH'(div_nxt[0]);
`ifdef CLK_DIV_HALF_CYCLE_EN
  assign thr = div_nxt[0] ? half_lo : half_hi;
`else
  assign thr = half_hi;
`endif
  assign tick_nxt = enable && (cnt_nxt == '0);
  assign term_nxt = enable && ((mode_nxt == CLK_DIV_MODE_PULSE) ? (cnt_nxt == '0) : (cnt_nxt < thr));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      div_q     <= WIDTH'(DIV_RESET);
      mode_q    <= CLK_DIV_MODE_PULSE;
      pend_div  <= WIDTH'(DIV_RESET);
      pend_mode <= CLK_DIV_MODE_PULSE;
      pending   <= 1'b0;
      run_q     <= 1'b0;
      tick      <= 1'b0;
      term_q    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      div_q     <= div_nxt;
      mode_q    <= mode_nxt;
      pend_div  <= pdiv_nxt;
      pend_mode <= pmode_nxt;
      pending   <= pend_nxt;
      run_q     <= enable;
      tick      <= tick_nxt;
      term_q    <= term_nxt;
    end
  end

`ifdef CLK_DIV_HALF_CYCLE_EN
  logic odd_half_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odd_half_q <= 1'b0;
    end else begin
      odd_half_q <= enable && (mode_nxt == CLK_DIV_MODE_HALF) && div_nxt[0];
    end
  end

  clk_div_negstage u_negstage (
    .clock    (clock),
    .reset    (reset),
    .pos_term (term_q),
    .odd_half (odd_half_q),
    .div_out  (div_out)
  );
`else
  assign div_out = term_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Directed self-checking bench for clk_div_n with hand-computed tick/div_out/pending sequences.
module tb_clk_div_n;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] div_in;
  logic             mode_in;
  logic             div_load;
  logic             div_out;
  logic             tick;
  logic             pending;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  clk_div_n #(.WIDTH(WIDTH), .DIV_RESET(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .div_load (div_load),
    .div_out  (div_out),
    .tick     (tick),
    .pending  (pending)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic et, input logic eo, input logic ep);
    chk({tag, ".tick"}, tick, et);
    chk({tag, ".div_out"}, div_out, eo);
    chk({tag, ".pending"}, pending, ep);
  endtask

  task automatic step(input string tag, input logic et, input logic eo, input logic ep);
    @(posedge clock);
    #1;
    chk_all(tag, et, eo, ep);
  endtask

  task automatic mid(input string tag, input logic eo);
    @(negedge clock);
    #1;
    chk({tag, ".mid_div_out"}, div_out, eo);
  endtask

  logic exp_mid1;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    div_in   = '0;
    mode_in  = 1'b0;
    div_load = 1'b0;
`ifdef CLK_DIV_HALF_CYCLE_EN
    exp_mid1 = 1'b0;
`else
    exp_mid1 = 1'b1;
`endif

    // Reset state
    step("rst0", 0, 0, 0);
    step("rst1", 0, 0, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // Default divisor 3, pulse mode
    step("d3_k0", 1, 1, 0);
    step("d3_k1", 0, 0, 0);
    step("d3_k2", 0, 0, 0);
    step("d3_k3", 1, 1, 0);
    step("d3_k4", 0, 0, 0);
    step("d3_k5", 0, 0, 0);
    step("d3_k6", 1, 1, 0);
    enable = 1'b0;
    step("idle0", 0, 0, 0);

    // Idle load N=4 half mode
    div_in = 8'd4; mode_in = 1'b1; div_load = 1'b1;
    step("ld4", 0, 0, 0);
    div_load = 1'b0; enable = 1'b1;
    step("h4_c0", 1, 1, 0);
    step("h4_c1", 0, 1, 0);
    step("h4_c2", 0, 0, 0);
    step("h4_c3", 0, 0, 0);
    step("h4_c0b", 1, 1, 0);
    step("h4_c1b", 0, 1, 0);
    step("h4_c2b", 0, 0, 0);
    step("h4_c3b", 0, 0, 0);
    enable = 1'b0;
    step("idle1", 0, 0, 0);

    // N=5 pulse, two loads mid-period (second overwrites), then N=2
    div_in = 8'd5; mode_in = 1'b0; div_load = 1'b1;
    step("ld5", 0, 0, 0);
    div_load = 1'b0; enable = 1'b1;
    step("p5_c0", 1, 1, 0);
    step("p5_c1", 0, 0, 0);
    div_in = 8'd6; div_load = 1'b1;
    step("p5_c2", 0, 0, 1);
    div_in = 8'd2;
    step("p5_c3", 0, 0, 1);
    div_load = 1'b0;
    step("p5_c4", 0, 0, 1);
    step("p2_c0", 1, 1, 0);
    step("p2_c1", 0, 0, 0);
    step("p2_c0b", 1, 1, 0);
    step("p2_c1b", 0, 0, 0);

    // Load on the wrap edge: N=3 half, applied immediately
    div_in = 8'd3; mode_in = 1'b1; div_load = 1'b1;
    step("h3_c0", 1, 1, 0);
    div_load = 1'b0;
    mid("h3_c0", 1);
    step("h3_c1", 0, 1, 0);
    mid("h3_c1", exp_mid1);
    step("h3_c2", 0, 0, 0);
    mid("h3_c2", 0);
    step("h3_c0b", 1, 1, 0);
    step("h3_c1b", 0, 1, 0);
    step("h3_c2b", 0, 0, 0);
    enable = 1'b0;
    step("idle2", 0, 0, 0);

    // Clamp: div_in=0 idle load, div_in=1 running load
    div_in = 8'd0; mode_in = 1'b0; div_load = 1'b1;
    step("ld0", 0, 0, 0);
    div_load = 1'b0; enable = 1'b1;
    step("z_c0", 1, 1, 0);
    step("z_c1", 0, 0, 0);
    step("z_c0b", 1, 1, 0);
    div_in = 8'd1; div_load = 1'b1;
    step("o_c1", 0, 0, 1);
    div_load = 1'b0;
    step("o_c0", 1, 1, 0);
    step("o_c1b", 0, 0, 0);
    step("o_c0b", 1, 1, 0);
    enable = 1'b0;
    step("idle3", 0, 0, 0);

    // N=7 half, pending load, then asynchronous reset mid-period
    div_in = 8'd7; mode_in = 1'b1; div_load = 1'b1;
    step("ld7", 0, 0, 0);
    div_load = 1'b0; enable = 1'b1;
    step("h7_c0", 1, 1, 0);
    step("h7_c1", 0, 1, 0);
    div_in = 8'd5; mode_in = 1'b0; div_load = 1'b1;
    step("h7_c2", 0, 1, 1);
    div_load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    step("rr_k0", 1, 1, 0);
    step("rr_k1", 0, 0, 0);
    step("rr_k2", 0, 0, 0);
    step("rr_k3", 1, 1, 0);
    step("rr_k4", 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_div_n.md
# clk_div_n

Parametrised, runtime-programmable integer clock divider. Generates a divided waveform (single-cycle pulse or near-50 % duty) plus a one-cycle period tick from the system clock. Divisor and mode changes are accepted at any time but applied only at a period boundary, so the output never glitches or produces a short period. Used wherever the design needs slow strobes or divided enables derived from `clock`.

## Interface
- `WIDTH`, 8, width of the divisor; legal divisors are 2 .. 2^WIDTH-1.
- `DIV_RESET`, 3, divisor in effect after reset; must satisfy 2 ≤ DIV_RESET < 2^WIDTH.

- `clock`  in  1  system clock; all state except the optional negedge stage is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run the divider; low holds it idle.
- `div_in`  in  WIDTH  requested divisor N; values 0 and 1 are clamped to 2.
- `mode_in`  in  1  requested mode: 0 = pulse, 1 = half duty.
- `div_load`  in  1  single-cycle strobe that captures `div_in` and `mode_in`.
- `div_out`  out  1  divided waveform.
- `tick`  out  1  high for one cycle at the start of every period.
- `pending`  out  1  a captured load is waiting for the next period boundary.

## Operation
- State: `cnt` (WIDTH bits, 0..N-1), active divisor `div_q`, active mode `mode_q`, pending divisor and mode, and a pending flag.
- Idle (`enable` = 0): `cnt` is held at 0 and `div_out` and `tick` are 0. A `div_load` is applied directly to `div_q`/`mode_q` and `pending` stays 0.
- Run: edge k counts from the first rising edge at which `enable` is sampled high (k = 0). After edge k, `cnt` = k mod N.
- Wrap: on the edge where `cnt` = `div_q` - 1, `cnt` returns to 0. If a load is pending, `div_q`/`mode_q` take the pending values on that same edge and `pending` clears.
- `div_load` while running: the request is captured and `pending` is set. A second load before the wrap overwrites the first. A load sampled on the wrap edge itself is applied at that wrap, and `pending` stays 0.
- `tick` is registered and equals (new `cnt` == 0) while enabled.
- `div_out` is registered:
  - Pulse mode: identical to `tick`.
  - Half mode: high while `cnt` < ceil(N/2). Odd N therefore gives ceil(N/2) cycles high and floor(N/2) cycles low.
- Dropping `enable` mid-period returns the block to idle on the next edge. The next enable restarts at k = 0 with the current `div_q`; a pending load is applied at that restart.

## Timing
- All outputs are registered. The first `tick` and `div_out` high appear after edge k = 0, i.e. one cycle after `enable` is sampled.
- Output period is exactly `div_q` cycles. A new divisor first affects the period that starts at the wrap.
- Reset values: `cnt` = 0, `div_q` = DIV_RESET, `mode_q` = pulse, `pending` = 0, `div_out` = 0, `tick` = 0, negedge flop = 0.
- Reset asserted mid-period clears all state asynchronously. After release, operation resumes from idle/k = 0.

## Configuration
- `CLK_DIV_HALF_CYCLE_EN` defined:
  - Adds a falling-edge retiming flop. For odd N in half mode, the posedge term is high while `cnt` < floor(N/2), and `div_out` = posedge term OR its half-cycle-delayed copy.
  - Result is exactly N/2 cycles high (N = 3 → 1.5 cycles high, 1.5 low).
  - Even N and pulse mode are unchanged.
  - In this configuration `div_out` is glitch-free but not purely posedge-registered.
- Macro undefined: no negedge logic; behaviour is as described in Operation.

## Structure
- `clk_div_pkg` holds:
  - Mode encodings `CLK_DIV_MODE_PULSE` = 0 and `CLK_DIV_MODE_HALF` = 1.
  - The minimum-divisor constant (2).
  - The clamp function applied to `div_in`.
- Sub-module `clk_div_negstage`: the falling-edge retiming flop plus OR, with asynchronous active-high reset. Instantiated only under `CLK_DIV_HALF_CYCLE_EN`.

## Test plan
- Reset, then `enable` = 1 with the default divisor → `tick` high every 3rd cycle starting 1 cycle after enable; `div_out` = `tick`.
- Idle load N = 4, half mode, then enable → `div_out` pattern 1,1,0,0 repeating; `tick` every 4 cycles.
- Running at N = 5, load N = 2 at `cnt` = 1 → `pending` = 1 until the wrap edge. The current 5-cycle period completes, then the period is 2 cycles; no period shorter than 2 appears.
- Half mode, N = 3, with and without `CLK_DIV_HALF_CYCLE_EN` → duty 1.5/1.5 cycles with the macro, 2/1 cycles without.
- Load `div_in` = 0 and `div_in` = 1 → both behave as N = 2. A load on the wrap edge takes effect immediately with `pending` never set.
- Assert `reset` mid-period at N = 7 → all outputs 0 immediately, `div_q` back to 3. After release with `enable` = 1, `tick` has a 3-cycle period.
